pc_fetch_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch for the RISC-V core against a variable-latency instruction memory with a req/ack handshake. Selects the next PC with fixed priority: trap, then branch/jump, then PC+4. Handles stalls, halt, fetch timeout and misaligned redirects. Sits between the control unit and the instruction memory, and replaces direct free-running PC updates.

---
 rtl/pc_fetch_sequencer.sv | 73 +++++++
 tb/tb_pc_fetch_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and sequences req/ack instruction fetch with trap/branch/halt/timeout handling
module pc_fetch_sequencer #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(4),
  parameter int              TIMEOUT      = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  output logic             o_instr_valid,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_trap,
  input  logic             i_halt,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic             o_fetch_err,
  output logic             o_halted
);
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HALTED} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_pc, w_pc_nx, w_redirect;
  logic [7:0]       r_cnt, w_cnt_nx;
  logic             w_acc;
  assign o_imem_req    = (r_state == FETCH && !i_stall) || r_state == WAIT;
  assign w_acc         = o_imem_req & i_imem_ack;
  assign o_instr_valid = w_acc;
  assign o_fetch_err   = r_state == WAIT && !i_imem_ack && r_cnt == TMO;
  assign o_halted      = r_state == HALTED;
  assign o_pc          = r_pc;
  assign o_imem_addr   = r_pc;
  assign o_pc_plus4    = r_pc + WIDTH'(4);
  // trap beats halt beats branch; a misaligned branch target traps
  assign w_redirect = i_trap ? TRAP_VECTOR :
                      i_halt ? r_pc :
                      !i_branch_taken ? o_pc_plus4 :
                      (i_branch_target[1:0] != 2'b00) ? TRAP_VECTOR : i_branch_target;
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_cnt_nx   = r_cnt;
    if (r_state == BOOT) begin
      w_state_nx = FETCH;
    end else if (w_acc) begin
      w_state_nx = (i_halt && !i_trap) ? HALTED : FETCH;
      w_pc_nx    = w_redirect;
      w_cnt_nx   = '0;
    end else if (o_fetch_err) begin
      w_state_nx = FETCH;
      w_pc_nx    = TRAP_VECTOR;
      w_cnt_nx   = '0;
    end else if (o_imem_req) begin
      w_state_nx = WAIT;
      w_cnt_nx   = r_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed table-driven bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;
  logic        clk = 0, rst_n = 0;
  logic        imem_req, imem_ack = 0, instr_valid, stall = 0, br = 0, trap = 0, halt = 0;
  logic        fetch_err, halted;
  logic [31:0] imem_addr, tgt = 0, pc, pc_plus4;
  int          n_pass = 0, n_tot = 0;

  typedef struct {
    logic stall, ack, br; logic [31:0] tgt; logic trap, halt;
    logic req; logic [31:0] addr; logic valid, err, hlt;
  } vec_t;

  pc_fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_ack(imem_ack), .o_instr_valid(instr_valid), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(tgt), .i_trap(trap), .i_halt(halt),
    .o_pc(pc), .o_pc_plus4(pc_plus4), .o_fetch_err(fetch_err), .o_halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, " req"}, 32'(imem_req), 32'(v.req));
    chk({tag, " addr"}, imem_addr, v.addr);
    chk({tag, " pc"}, pc, v.addr);
    chk({tag, " pc_plus4"}, pc_plus4, v.addr + 32'd4);
    chk({tag, " valid"}, 32'(instr_valid), 32'(v.valid));
    chk({tag, " fetch_err"}, 32'(fetch_err), 32'(v.err));
    chk({tag, " halted"}, 32'(halted), 32'(v.hlt));
  endtask

  // drive inputs mid-cycle, check on the falling edge, then advance past the next rising edge
  task automatic apply(input string tag, input vec_t v);
    stall = v.stall; imem_ack = v.ack; br = v.br; tgt = v.tgt; trap = v.trap; halt = v.halt;
    @(negedge clk);
    chk_out(tag, v);
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic s, a, b, input logic [31:0] t, input logic tr, h,
                              input logic rq, input logic [31:0] ad, input logic vl, er, hl);
    vec_t v;
    v.stall = s; v.ack = a; v.br = b; v.tgt = t; v.trap = tr; v.halt = h;
    v.req = rq; v.addr = ad; v.valid = vl; v.err = er; v.hlt = hl;
    return v;
  endfunction

  vec_t tbl[20];

  initial begin
    //           stall ack br tgt           trap halt  req addr          valid err hlt
    tbl[0]  = mk(0, 1, 0, 32'h0,        0, 0,  0, 32'h0,        0, 0, 0); // BOOT
    tbl[1]  = mk(0, 1, 0, 32'h0,        0, 0,  1, 32'h0,        1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 32'h0,        0, 0,  1, 32'h4,        1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 32'h0,        0, 0,  1, 32'h8,        0, 0, 0); // into WAIT
    tbl[4]  = mk(1, 0, 0, 32'h0,        0, 0,  1, 32'h8,        0, 0, 0); // stall ignored in WAIT
    tbl[5]  = mk(0, 0, 0, 32'h0,        0, 0,  1, 32'h8,        0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 32'h0,        0, 0,  1, 32'h8,        1, 0, 0);
    tbl[7]  = mk(1, 1, 0, 32'h0,        0, 0,  0, 32'hC,        0, 0, 0); // stall blocks req in FETCH
    tbl[8]  = mk(0, 1, 1, 32'h100,      0, 0,  1, 32'hC,        1, 0, 0);
    tbl[9]  = mk(0, 1, 1, 32'h102,      0, 0,  1, 32'h100,      1, 0, 0); // misaligned
    tbl[10] = mk(0, 1, 1, 32'h200,      1, 0,  1, 32'h4,        1, 0, 0); // trap beats branch
    tbl[11] = mk(0, 0, 1, 32'h300,      0, 0,  1, 32'h4,        0, 0, 0); // branch ignored w/o valid
    tbl[12] = mk(0, 1, 0, 32'h0,        0, 0,  1, 32'h4,        1, 0, 0);
    tbl[13] = mk(0, 1, 0, 32'h0,        1, 1,  1, 32'h8,        1, 0, 0); // trap beats halt
    tbl[14] = mk(0, 1, 1, 32'hFFFFFFFC, 0, 0,  1, 32'h4,        1, 0, 0);
    tbl[15] = mk(0, 1, 0, 32'h0,        0, 0,  1, 32'hFFFFFFFC, 1, 0, 0); // wraps to 0
    tbl[16] = mk(0, 1, 1, 32'h40,       0, 0,  1, 32'h0,        1, 0, 0);
    tbl[17] = mk(0, 1, 0, 32'h0,        0, 1,  1, 32'h40,       1, 0, 0); // halt
    tbl[18] = mk(0, 1, 1, 32'h80,       1, 0,  0, 32'h40,       0, 0, 1);
    tbl[19] = mk(0, 1, 0, 32'h0,        0, 1,  0, 32'h40,       0, 0, 1);

    @(negedge clk);
    chk_out("reset", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 20; i++) apply($sformatf("row%0d", i), tbl[i]);

    // leave HALTED through asynchronous reset
    rst_n = 0; #1;
    chk_out("halt_rst", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1;
    apply("boot2", mk(0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    apply("to_20", mk(0, 1, 1, 32'h20, 0, 0, 1, 32'h0, 1, 0, 0));

    // fetch timeout: request cycle then 15 wait cycles, error on the last
    for (int k = 0; k <= 15; k++)
      apply($sformatf("tmo%0d", k), mk(0, 0, 0, 0, 0, 0, 1, 32'h20, 0, logic'(k == 15), 0));
    apply("after_tmo", mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0));
    apply("wait_again", mk(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0, 0));

    // asynchronous reset while in WAIT
    rst_n = 0; #1;
    chk_out("wait_rst", mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1;
    apply("boot3", mk(0, 1, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    apply("resume0", mk(0, 1, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0));
    apply("resume4", mk(0, 1, 0, 0, 0, 0, 1, 32'h4, 1, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
